// File: rtl/fpu_exec_seq.sv
// Execute-stage sequencer for single-precision FP instructions.
// Sign-injection and min/max are computed locally; add/sub/mul/div/sqrt are
// handed to an external arithmetic core over a start/done handshake with a
// watchdog. Produces the FP register-file write port and the pipeline stall.
module fpu_exec_seq #(
  parameter int unsigned CORE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [3:0]  fp_operationE,
  input  logic [2:0]  rmE,
  input  logic [4:0]  rdE,
  input  logic [31:0] fa,
  input  logic [31:0] fb,
  output logic        core_start,
  output logic [2:0]  core_op,
  output logic [2:0]  core_rm,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic        core_done,
  input  logic [31:0] core_result,
  output logic        StallFPU,
  output logic        fp_we,
  output logic [4:0]  fp_rd,
  output logic [31:0] fp_wdata,
  output logic        fp_illegal,
  output logic        fp_timeout
);

  localparam int unsigned CntW = (CORE_TIMEOUT > 1) ? $clog2(CORE_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CORE_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StCore, StWb} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            core_start_q, core_start_d;
  logic [2:0]      core_op_q, core_op_d;
  logic [2:0]      core_rm_q, core_rm_d;
  logic [31:0]     core_a_q, core_a_d;
  logic [31:0]     core_b_q, core_b_d;
  logic            fp_we_q, fp_we_d;
  logic [4:0]      fp_rd_q, fp_rd_d;
  logic [31:0]     fp_wdata_q, fp_wdata_d;
  logic            fp_illegal_q, fp_illegal_d;
  logic            fp_timeout_q, fp_timeout_d;

  logic        a_nan, b_nan, a_lt_b;
  logic [31:0] local_res;

  // Sign-magnitude ordering (-0 < +0) and the locally computed results.
  always_comb begin
    a_nan = (fa[30:23] == 8'hFF) && (fa[22:0] != 23'd0);
    b_nan = (fb[30:23] == 8'hFF) && (fb[22:0] != 23'd0);
    if (fa[31] != fb[31]) begin
      a_lt_b = fa[31];
    end else if (fa[31]) begin
      a_lt_b = fa[30:0] > fb[30:0];
    end else begin
      a_lt_b = fa[30:0] < fb[30:0];
    end
    local_res = 32'd0;
    case (fp_operationE)
      4'd5: local_res = {fb[31], fa[30:0]};
      4'd6: local_res = {~fb[31], fa[30:0]};
      4'd7: local_res = {fa[31] ^ fb[31], fa[30:0]};
      4'd8, 4'd9: begin
        if (a_nan && b_nan) begin
          local_res = 32'h7FC0_0000;
        end else if (a_nan) begin
          local_res = fb;
        end else if (b_nan) begin
          local_res = fa;
        end else if (fp_operationE == 4'd8) begin
          local_res = a_lt_b ? fa : fb;
        end else begin
          local_res = a_lt_b ? fb : fa;
        end
      end
      default: local_res = 32'd0;
    endcase
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_start_d = 1'b0;
    core_op_d    = core_op_q;
    core_rm_d    = core_rm_q;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    fp_we_d      = 1'b0;
    fp_rd_d      = fp_rd_q;
    fp_wdata_d   = fp_wdata_q;
    fp_illegal_d = 1'b0;
    fp_timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (StartE) begin
          if (fp_operationE >= 4'd10) begin
            fp_illegal_d = 1'b1;
          end else if (fp_operationE >= 4'd5) begin
            fp_rd_d    = rdE;
            fp_wdata_d = local_res;
            fp_we_d    = 1'b1;
            state_d    = StWb;
          end else begin
            fp_rd_d      = rdE;
            core_op_d    = fp_operationE[2:0];
            core_rm_d    = rmE;
            core_a_d     = fa;
            core_b_d     = fb;
            core_start_d = 1'b1;
            cnt_d        = '0;
            state_d      = StCore;
          end
        end
      end
      StCore: begin
        // A done in the watchdog's final cycle still wins.
        if (core_done) begin
          fp_wdata_d = core_result;
          fp_we_d    = 1'b1;
          state_d    = StWb;
        end else if (cnt_q == CntLast) begin
          fp_timeout_d = 1'b1;
          state_d      = StWb;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      core_start_q <= 1'b0;
      core_op_q    <= 3'd0;
      core_rm_q    <= 3'd0;
      core_a_q     <= 32'd0;
      core_b_q     <= 32'd0;
      fp_we_q      <= 1'b0;
      fp_rd_q      <= 5'd0;
      fp_wdata_q   <= 32'd0;
      fp_illegal_q <= 1'b0;
      fp_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_start_q <= core_start_d;
      core_op_q    <= core_op_d;
      core_rm_q    <= core_rm_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      fp_we_q      <= fp_we_d;
      fp_rd_q      <= fp_rd_d;
      fp_wdata_q   <= fp_wdata_d;
      fp_illegal_q <= fp_illegal_d;
      fp_timeout_q <= fp_timeout_d;
    end
  end

  // Stall is the only combinational output.
  always_comb begin
    StallFPU = ((state_q == StIdle) && StartE && (fp_operationE <= 4'd9)) ||
               (state_q == StCore);
  end

  assign core_start = core_start_q;
  assign core_op    = core_op_q;
  assign core_rm    = core_rm_q;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign fp_we      = fp_we_q;
  assign fp_rd      = fp_rd_q;
  assign fp_wdata   = fp_wdata_q;
  assign fp_illegal = fp_illegal_q;
  assign fp_timeout = fp_timeout_q;

endmodule
